// File: rtl/riscv_mem_pkg.sv
// Shared types and default timing constants for the unified memory port arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_grant_sel.sv
// Grant choice between fetch and data: data wins unless fetch has waited
// through the maximum number of consecutive data grants.
module arb_grant_sel
  import riscv_mem_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  logic   starved,
  output logic   grant,
  output owner_t owner
);

  always_comb begin
    grant = if_req | d_req;
    owner = OWN_D;
    if (if_req && (!d_req || starved)) begin
      owner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: fixed data priority with
// a fetch starvation guard, fixed-latency access FSM, registered outputs.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);

  arb_state_t        state, state_nxt;
  owner_t            owner, owner_nxt;
  owner_t            grant_owner;
  logic              grant;
  logic              op_we, op_we_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic              mem_en_nxt, mem_we_nxt, if_ack_nxt, d_ack_nxt, busy_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic [BE_W-1:0]   mem_be_nxt;

  arb_grant_sel u_grant_sel (
    .if_req  (if_req),
    .d_req   (d_req),
    .starved (starve_cnt == CNT_MAX),
    .grant   (grant),
    .owner   (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      op_we      <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      op_we      <= op_we_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_be     <= mem_be_nxt;
      if_ack     <= if_ack_nxt;
      d_ack      <= d_ack_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      busy       <= busy_nxt;
    end
  end

  // Outputs are computed one cycle early so that they appear registered in the
  // state they belong to (mem_en in ISSUE, ack in RESP).
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    op_we_nxt      = op_we;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    mem_en_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_be_nxt     = mem_be;
    if_ack_nxt     = 1'b0;
    d_ack_nxt      = 1'b0;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;

    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt  = ISSUE;
          owner_nxt  = grant_owner;
          mem_en_nxt = 1'b1;
          if (grant_owner == OWN_D) begin
            op_we_nxt     = d_we;
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            mem_be_nxt    = d_we ? d_be : '1;
            if (!if_req) begin
              starve_cnt_nxt = '0;
            end else if (starve_cnt != CNT_MAX) begin
              starve_cnt_nxt = starve_cnt + CNT_W'(1);
            end
          end else begin
            op_we_nxt      = 1'b0;
            mem_addr_nxt   = if_addr;
            mem_be_nxt     = '1;
            starve_cnt_nxt = '0;
          end
        end
      end
      ISSUE: begin
        state_nxt   = WAIT;
        lat_cnt_nxt = LAT_LOAD;
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt  = RESP;
          if_ack_nxt = (owner == OWN_IF);
          d_ack_nxt  = (owner == OWN_D);
          if (owner == OWN_IF) begin
            if_rdata_nxt = mem_rdata;
          end else if (!op_we) begin
            d_rdata_nxt = mem_rdata;
          end
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
